// File: rtl/latch_port_reader.sv
// Brings asynchronous latched status flags into the clock domain for a
// KCPSM3 processor: filter, interrupt on new rises, read snapshot, clear latches.
module latch_port_reader #(
  parameter int unsigned WIDTH         = 8,
  parameter logic [7:0]  PORT_DATA     = 8'h00,
  parameter logic [7:0]  PORT_STATUS   = 8'h01,
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] latch_q,
  input  logic [7:0]       port_id,
  input  logic             read_strobe,
  input  logic             interrupt_ack,
  output logic [7:0]       in_port,
  output logic             interrupt,
  output logic [WIDTH-1:0] clear_latch
);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    CLEAR
  } state_t;

  localparam logic [3:0] STABLE_LIM = 4'(STABLE_CYCLES);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] snapshot_q, snapshot_d;
  logic [WIDTH-1:0] clear_q, clear_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic             deferred_q, deferred_d;
  logic             irq_q, irq_d;
  logic [7:0]       in_port_q, in_port_d;

  logic [WIDTH-1:0] rise;
  logic [7:0]       snap_ext;
  logic             accept;
  logic             evt;
  logic             data_rd;

  always_comb begin
    sync1_d  = latch_q;
    sync2_d  = sync1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q < STABLE_LIM) begin
      cnt_d = cnt_q + 4'd1;
    end
    accept = (sync2_q == cand_q) && (cnt_q == STABLE_LIM)
          && (cand_q != stable_q);
    rise   = cand_q & ~stable_q;
    evt    = accept && (|rise);
    if (accept) stable_d = cand_q;
  end

  assign data_rd = read_strobe && (port_id == PORT_DATA);

  always_comb begin
    state_d    = state_q;
    snapshot_d = snapshot_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    deferred_d = deferred_q;
    irq_d      = irq_q;
    clear_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (evt || deferred_q) begin
          // a deferred event was already folded into stable
          snapshot_d = evt ? cand_q : stable_q;
          pending_d  = 1'b1;
          irq_d      = 1'b1;
          deferred_d = 1'b0;
          state_d    = PEND;
        end
      end
      PEND: begin
        if (interrupt_ack) irq_d = 1'b0;
        if (data_rd) begin
          clear_d   = snapshot_q;
          pending_d = 1'b0;
          overrun_d = 1'b0;
          irq_d     = 1'b0;
          state_d   = CLEAR;
          if (evt) deferred_d = 1'b1;
        end else if (evt) begin
          overrun_d  = 1'b1;
          deferred_d = 1'b1;
        end
      end
      CLEAR: begin
        state_d = IDLE;
        if (evt) deferred_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    snap_ext = '0;
    snap_ext[WIDTH-1:0] = snapshot_q;
    if (port_id == PORT_DATA) begin
      in_port_d = snap_ext;
    end else if (port_id == PORT_STATUS) begin
      in_port_d = {6'b0, overrun_q, pending_q};
    end else begin
      in_port_d = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      cand_q     <= '0;
      stable_q   <= '0;
      snapshot_q <= '0;
      clear_q    <= '0;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      deferred_q <= 1'b0;
      irq_q      <= 1'b0;
      in_port_q  <= '0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      snapshot_q <= snapshot_d;
      clear_q    <= clear_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      deferred_q <= deferred_d;
      irq_q      <= irq_d;
      in_port_q  <= in_port_d;
    end
  end

  assign in_port     = in_port_q;
  assign interrupt   = irq_q;
  assign clear_latch = clear_q;

endmodule

// File: tb/tb_latch_port_reader.sv
// Scoreboard bench for latch_port_reader: stimulus queues expectations,
// monitors pop them when the DUT shows reads, clear pulses or irq changes.
module tb_latch_port_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] latch_q = 8'h00;
  logic [7:0] port_id = 8'h00;
  logic       read_strobe = 1'b0;
  logic       interrupt_ack = 1'b0;
  logic [7:0] in_port;
  logic       interrupt;
  logic [7:0] clear_latch;

  latch_port_reader dut (
    .clk           (clk),
    .reset         (reset),
    .latch_q       (latch_q),
    .port_id       (port_id),
    .read_strobe   (read_strobe),
    .interrupt_ack (interrupt_ack),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .clear_latch   (clear_latch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } ev_t;

  typedef struct {
    logic [7:0] inp;
    logic       irq;
    logic [7:0] clr;
  } probe_t;

  ev_t        irq_q[$];
  ev_t        clr_q[$];
  logic [7:0] rd_q[$];
  probe_t     probe_q[$];
  event       probe_ev;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(logic [7:0] p, logic [7:0] exp);
    port_id     = p;
    read_strobe = 1'b1;
    rd_q.push_back(exp);
    @(negedge clk);
    read_strobe = 1'b0;
  endtask

  task automatic exp_irq(int c, logic lvl);
    ev_t e;
    e.cyc = c;
    e.val = {7'b0, lvl};
    irq_q.push_back(e);
  endtask

  task automatic exp_clr(int c, logic [7:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    clr_q.push_back(e);
  endtask

  task automatic probe(logic [7:0] inp, logic irq, logic [7:0] clr);
    probe_t p;
    p.inp = inp;
    p.irq = irq;
    p.clr = clr;
    probe_q.push_back(p);
    -> probe_ev;
  endtask

  initial begin : mon
    logic rd_hit;
    logic irq_prev;
    ev_t  e;
    irq_prev = 1'b0;
    forever begin
      @(posedge clk);
      rd_hit = read_strobe;
      @(negedge clk);
      if (rd_hit) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("in_port", in_port, rd_q.pop_front());
      end
      if (clear_latch != 8'h00) begin
        if (clr_q.size() == 0) begin
          chk("clr_unexpected", clear_latch, 0);
        end else begin
          e = clr_q.pop_front();
          chk("clr_val", clear_latch, e.val);
          chk("clr_cyc", cyc, e.cyc);
        end
      end
      if (interrupt !== irq_prev) begin
        if (irq_q.size() == 0) begin
          chk("irq_unexpected", interrupt, irq_prev);
        end else begin
          e = irq_q.pop_front();
          chk("irq_lvl", interrupt, e.val);
          chk("irq_cyc", cyc, e.cyc);
        end
        irq_prev = interrupt;
      end
    end
  end

  initial begin : probe_mon
    probe_t p;
    forever begin
      @(probe_ev);
      if (probe_q.size() == 0) begin
        chk("probe_unexpected", 1, 0);
      end else begin
        p = probe_q.pop_front();
        chk("probe_in_port", in_port, p.inp);
        chk("probe_irq", interrupt, p.irq);
        chk("probe_clr", clear_latch, p.clr);
      end
    end
  end

  initial begin : stim
    tick(3);
    probe(8'h00, 1'b0, 8'h00);
    reset = 1'b0;
    tick(2);
    rd(8'h01, 8'h00);

    // single flag
    latch_q = 8'h04;
    exp_irq(cyc + 6, 1'b1);
    tick(8);
    exp_clr(cyc + 1, 8'h04);
    exp_irq(cyc + 1, 1'b0);
    rd(8'h00, 8'h04);
    latch_q = 8'h00;
    tick(10);
    rd(8'h01, 8'h00);

    // glitch of two cycles
    latch_q = 8'h01;
    tick(2);
    latch_q = 8'h00;
    tick(10);
    rd(8'h01, 8'h00);

    // overrun
    latch_q = 8'h01;
    exp_irq(cyc + 6, 1'b1);
    tick(8);
    latch_q = 8'h03;
    tick(8);
    rd(8'h01, 8'h03);
    exp_clr(cyc + 1, 8'h01);
    exp_irq(cyc + 1, 1'b0);
    exp_irq(cyc + 3, 1'b1);
    rd(8'h00, 8'h01);
    latch_q = 8'h02;
    rd(8'h01, 8'h00);
    tick(2);
    exp_clr(cyc + 1, 8'h03);
    exp_irq(cyc + 1, 1'b0);
    rd(8'h00, 8'h03);
    latch_q = 8'h00;
    tick(10);

    // acknowledge without read
    latch_q = 8'h10;
    exp_irq(cyc + 6, 1'b1);
    tick(8);
    interrupt_ack = 1'b1;
    exp_irq(cyc + 1, 1'b0);
    tick(1);
    interrupt_ack = 1'b0;
    rd(8'h01, 8'h01);
    exp_clr(cyc + 1, 8'h10);
    rd(8'h00, 8'h10);
    latch_q = 8'h00;
    tick(10);

    // event coincident with data read
    latch_q = 8'h01;
    exp_irq(cyc + 6, 1'b1);
    tick(8);
    latch_q = 8'h03;
    tick(5);
    exp_clr(cyc + 1, 8'h01);
    exp_irq(cyc + 1, 1'b0);
    exp_irq(cyc + 3, 1'b1);
    rd(8'h00, 8'h01);
    latch_q = 8'h02;
    tick(3);
    exp_clr(cyc + 1, 8'h03);
    exp_irq(cyc + 1, 1'b0);
    rd(8'h00, 8'h03);
    latch_q = 8'h00;
    tick(10);

    // reset mid-PEND
    latch_q = 8'h20;
    port_id = 8'h00;
    exp_irq(cyc + 6, 1'b1);
    tick(8);
    #2;
    reset   = 1'b1;
    latch_q = 8'h00;
    exp_irq(cyc + 1, 1'b0);
    #1;
    probe(8'h00, 1'b0, 8'h00);
    tick(1);
    reset = 1'b0;
    tick(1);
    rd(8'h01, 8'h00);
    rd(8'h00, 8'h00);
    tick(2);

    // reset while the clear pulse is high
    latch_q = 8'h08;
    exp_irq(cyc + 6, 1'b1);
    tick(8);
    exp_clr(cyc + 1, 8'h08);
    exp_irq(cyc + 1, 1'b0);
    rd(8'h00, 8'h08);
    #2;
    reset   = 1'b1;
    latch_q = 8'h00;
    #1;
    probe(8'h00, 1'b0, 8'h00);
    tick(1);
    reset = 1'b0;
    tick(3);
    rd(8'h01, 8'h00);
    tick(2);

    chk("irq_left", irq_q.size(), 0);
    chk("clr_left", clr_q.size(), 0);
    chk("rd_left", rd_q.size(), 0);
    chk("probe_left", probe_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
